// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ADD/SUB/CMP controller driving one 1-bit adder
// slice for WIDTH cycles, LSB first, with a start/done handshake.
//
// Optional feature macro: SERIAL_ALU_SUB_EN
//   defined     -> op=10 computes a-b (b inverted, carry-in 1)
//   not defined -> op=10 decodes as ADD
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high reset
//   start   in   1      request, sampled only in IDLE
//   op      in   2      00=ADD, 01=CMP, 10=SUB (macro) / ADD, 11=ADD
//   a, b    in   WIDTH  operands, latched on accepted start
//   busy    out  1      high while the slice is sequencing (RUN)
//   done    out  1      one-cycle pulse, result/cout/eq valid
//   result  out  WIDTH  sum/difference, zero for CMP
//   cout    out  1      final carry, zero for CMP
//   eq      out  1      latched a == latched b
module serial_alu_sequencer #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             eq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic             load_c;
   logic             shift_c;
   logic             last_c;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             eq_acc;
   logic             cmp_q;
`ifdef SERIAL_ALU_SUB_EN
   logic             sub_q;
`endif

   logic             a0;
   logic             b0;
   logic             bx;
   logic             sum_bit;
   logic             carry_nxt;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control strobes decoded from the current state
   always_comb begin
      load_c  = 1'b0;
      shift_c = 1'b0;
      last_c  = 1'b0;
      case (state)
         IDLE: load_c = start;
         RUN: begin
            shift_c = 1'b1;
            last_c  = (cnt == LAST_BIT);
         end
         default: ;
      endcase
   end

   // One-bit adder slice; b is inverted for SUB only
   always_comb begin
      a0 = a_sh[0];
      b0 = b_sh[0];
`ifdef SERIAL_ALU_SUB_EN
      bx = b0 ^ sub_q;
`else
      bx = b0;
`endif
      sum_bit   = a0 ^ bx ^ carry;
      carry_nxt = (a0 & bx) | (a0 & carry) | (bx & carry);
   end

   // Datapath and registered outputs; visible results change only on the last bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         eq     <= 1'b0;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         eq_acc <= 1'b0;
         cmp_q  <= 1'b0;
`ifdef SERIAL_ALU_SUB_EN
         sub_q  <= 1'b0;
`endif
      end else begin
         busy <= (state_nxt == RUN);
         done <= (state_nxt == DONE);
         if (load_c) begin
            a_sh   <= a;
            b_sh   <= b;
            acc    <= '0;
            cnt    <= '0;
            eq_acc <= 1'b1;
            cmp_q  <= (op == 2'b01);
`ifdef SERIAL_ALU_SUB_EN
            sub_q  <= (op == 2'b10);
            carry  <= (op == 2'b10);
`else
            carry  <= 1'b0;
`endif
         end else if (shift_c) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            acc    <= {sum_bit, acc[WIDTH-1:1]};
            carry  <= carry_nxt;
            eq_acc <= eq_acc & ~(a0 ^ b0);
            cnt    <= cnt + CNT_W'(1);
            if (last_c) begin
               result <= cmp_q ? '0 : {sum_bit, acc[WIDTH-1:1]};
               cout   <= ~cmp_q & carry_nxt;
               eq     <= eq_acc & ~(a0 ^ b0);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Testbench for serial_alu_sequencer: an arithmetic reference model tracks the
// expected outputs cycle by cycle; directed literal cases pin the model.
module tb_serial_alu_sequencer;
   localparam int unsigned WIDTH = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             eq;

   serial_alu_sequencer #(.WIDTH(WIDTH), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout), .eq(eq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected {cout, result} from plain arithmetic
   function automatic logic [WIDTH:0] model_sum(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH:0] s;
      if (o == 2'b01) s = '0;
`ifdef SERIAL_ALU_SUB_EN
      else if (o == 2'b10) s = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
`endif
      else s = {1'b0, x} + {1'b0, y};
      return s;
   endfunction

   // Reference model: counts edges since an accepted start
   bit               m_active = 1'b0;
   int               m_e = 0;
   logic [1:0]       m_op = '0;
   logic [WIDTH-1:0] m_a = '0;
   logic [WIDTH-1:0] m_b = '0;
   logic             exp_busy = 1'b0;
   logic             exp_done = 1'b0;
   logic [WIDTH-1:0] exp_result = '0;
   logic             exp_cout = 1'b0;
   logic             exp_eq = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 1'b0; m_e = 0;
         exp_busy = 1'b0; exp_done = 1'b0;
         exp_result = '0; exp_cout = 1'b0; exp_eq = 1'b0;
      end else if (!m_active) begin
         exp_done = 1'b0;
         if (start) begin
            m_active = 1'b1; m_e = 0;
            m_op = op; m_a = a; m_b = b;
            exp_busy = 1'b1;
         end
      end else begin
         m_e++;
         if (m_e == WIDTH) begin
            {exp_cout, exp_result} = model_sum(m_op, m_a, m_b);
            exp_eq   = (m_a == m_b);
            exp_done = 1'b1;
            exp_busy = 1'b0;
         end else if (m_e == WIDTH + 1) begin
            exp_done = 1'b0;
            m_active = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",   32'(busy),   32'(exp_busy));
         check("done",   32'(done),   32'(exp_done));
         check("result", 32'(result), 32'(exp_result));
         check("cout",   32'(cout),   32'(exp_cout));
         check("eq",     32'(eq),     32'(exp_eq));
      end
   end

   // Directed operation with literal expectations; latency counted in edges after the accepting edge
   task automatic run_lit(input string name, input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] r,
                          input logic c, input logic e);
      int lat;
      lat = 0;
      @(posedge clk); #2;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #2;
      start = 1'b0; op = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      check({name, "_busy"}, 32'(busy), 32'd1);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
         if (i > 1) start = 1'b1;  // ignored while running
      end
      start = 1'b0;
      check({name, "_latency"}, 32'(lat), 32'(WIDTH));
      check({name, "_result"}, 32'(result), 32'(r));
      check({name, "_cout"}, 32'(cout), 32'(c));
      check({name, "_eq"}, 32'(eq), 32'(e));
   endtask

   initial begin
      int t0;
      int t1;
      int nd;
      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      #1 reset = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_eq", 32'(eq), 32'd0);
      #1 reset = 1'b0;

      run_lit("add_1_1",   2'b00, 5'b00001, 5'b00001, 5'b00010, 1'b0, 1'b1);
      run_lit("add_noov",  2'b00, 5'b11100, 5'b00011, 5'b11111, 1'b0, 1'b0);
      run_lit("add_ovf",   2'b00, 5'b11111, 5'b00001, 5'b00000, 1'b1, 1'b0);
      run_lit("add_op11",  2'b11, 5'b01010, 5'b00110, 5'b10000, 1'b0, 1'b0);
      run_lit("cmp_ne",    2'b01, 5'b10101, 5'b10100, 5'b00000, 1'b0, 1'b0);
      run_lit("cmp_eq",    2'b01, 5'b01100, 5'b01100, 5'b00000, 1'b0, 1'b1);
`ifdef SERIAL_ALU_SUB_EN
      run_lit("sub_pos",   2'b10, 5'b00101, 5'b00011, 5'b00010, 1'b1, 1'b0);
      run_lit("sub_neg",   2'b10, 5'b00001, 5'b00100, 5'b11101, 1'b0, 1'b0);
`else
      run_lit("op10_add",  2'b10, 5'b00001, 5'b00001, 5'b00010, 1'b0, 1'b1);
`endif

      // start held high: one done every WIDTH+2 cycles
      @(posedge clk); #2;
      start = 1'b1; op = 2'b00; a = 5'd3; b = 5'd9;
      t0 = -1; t1 = -1; nd = 0;
      for (int i = 0; i < 40 && nd < 3; i++) begin
         @(posedge clk); #1;
         if (done) begin
            nd++;
            if (nd >= 2) check("period", 32'(cyc - t0), 32'(WIDTH + 2));
            t0 = cyc;
         end
      end
      check("period_count", 32'(nd), 32'd3);
      #1 start = 1'b0;
      repeat (WIDTH + 3) @(posedge clk);

      // randomized traffic, including start pulses while busy
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #2;
         start = ($urandom_range(0, 2) == 0);
         op    = 2'($urandom);
         a     = WIDTH'($urandom);
         b     = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
      end
      start = 1'b0;
      repeat (WIDTH + 3) @(posedge clk);

      // reset mid-RUN aborts with no later done
      @(posedge clk); #2;
      start = 1'b1; op = 2'b00; a = 5'b11111; b = 5'b11111;
      @(posedge clk); #2;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      check("midrst_eq", 32'(eq), 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      check("midrst_no_done", 32'(nd), 32'd0);

      run_lit("post_rst", 2'b00, 5'b00111, 5'b00001, 5'b01000, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #3 chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
